adma_as_atx_burst_gen: RTL
==========================

# adma_as_atx_burst_gen

Multi-channel, boundary-aware AXI burst generator for the ADMA address-side path. It accepts one DMA transaction at a time: channel tag, source and destination word addresses, and word length. It splits the transaction into AXI read/write burst pairs, each limited by the CSR burst length, by AXI 4 KB boundaries on both sides independently, and by the 16-beat AXI FIXED-burst limit. It sits between the channel arbiter and the AR/AW issue logic, and replaces the single-shot combinational splitter with a registered, CSR-snapshotting state machine.

## Interface
- DMA_CHN_NUM, 4: number of DMA channels.
- DMA_LENGTH_W, 16: width of the transaction length field.
- SRC_ADDR_W, 32: source address width, in bytes.
- DST_ADDR_W, 32: destination address width, in bytes.
- MST_ID_W, 5: AXI ID width.
- ATX_LEN_W, 8: AXI AxLEN width.
- DATA_W, 32: AXI data width in bits; bytes per word = DATA_W/8.
- BOUND_W, 12: log2 of the AXI address boundary in bytes.
- DMA_CHN_NUM_W, $clog2(DMA_CHN_NUM): derived; do not override.

Ports (clock and reset first):
- clk  in  1  the single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- tx_chn_id  in  DMA_CHN_NUM_W  channel tag of the incoming transaction.
- tx_src_addr  in  SRC_ADDR_W  source byte address; always word-aligned.
- tx_dst_addr  in  DST_ADDR_W  destination byte address; always word-aligned.
- tx_len  in  DMA_LENGTH_W  encoded length; number of words = tx_len+1.
- tx_vld  in  1  transaction valid.
- tx_rdy  out  1  transaction ready.
- atx_id  in  MST_ID_W  CSR: AXI ID.
- atx_src_burst  in  2  CSR: source burst type (00 FIXED, 01 INCR).
- atx_dst_burst  in  2  CSR: destination burst type (00 FIXED, 01 INCR).
- atx_wd_per_burst  in  DMA_LENGTH_W  CSR: encoded maximum words per burst.
- arid, araddr, arlen, arburst  out  MST_ID_W/SRC_ADDR_W/ATX_LEN_W/2  read burst fields.
- awid, awaddr, awlen, awburst  out  MST_ID_W/DST_ADDR_W/ATX_LEN_W/2  write burst fields.
- atx_chn_id  out  DMA_CHN_NUM_W  channel tag of the current burst.
- atx_vld  out  1  burst valid.
- atx_rdy  in  1  burst ready.
- atx_start  out  1  burst accepted this cycle (atx_vld & atx_rdy).
- atx_start_last  out  1  atx_start for the final burst of the transaction.
- busy  out  1  a transaction is in progress (state is not IDLE).

## Operation
States:
- IDLE: tx_rdy=1.
  - On tx_vld, latch chn_id, both addresses, and rem = tx_len+1 (DMA_LENGTH_W+1 bits; no overflow).
  - In the same cycle, snapshot atx_id, both burst types, and cap = atx_wd_per_burst+1.
  - Go to CALC.
  - CSR changes after this point are ignored until the next accept.
- CALC: compute the burst word count n = min(rem, cap, 2^ATX_LEN_W, fix_lim, src_bnd, dst_bnd), where:
  - fix_lim = 16 if either side is FIXED, else unlimited.
  - src_bnd = (2^BOUND_W − src_addr[BOUND_W-1:0]) / (DATA_W/8) if the source is INCR, else unlimited. dst_bnd is computed the same way on the destination side.
  - Register arlen = awlen = n−1, araddr/awaddr = current addresses, and last = (rem == n).
  - Go to ISSUE.
- ISSUE: atx_vld=1; all outputs are held stable until atx_rdy.
  - On atx_rdy: rem −= n; each INCR address += n·(DATA_W/8); FIXED addresses are unchanged.
  - If last, go to IDLE; otherwise go to CALC.
- Reserved or unknown burst encodings are treated as FIXED.
- Address arithmetic wraps modulo 2^ADDR_W.

## Timing
- Reset:
  - State goes to IDLE.
  - tx_rdy=0 while rst is high; tx_rdy=1 in the first cycle after rst deasserts.
  - atx_vld, atx_start, atx_start_last, busy = 0.
  - All registered burst fields and atx_chn_id = 0.
- Reset mid-operation: the transaction is discarded. atx_vld is 0 on the cycle after rst is sampled high. No partial bursts are issued afterwards.
- Latency:
  - tx accepted at cycle T; first atx_vld at T+2.
  - Each following burst has atx_vld 2 cycles after the previous atx_start.
  - tx_rdy returns 1 the cycle after atx_start_last.
- No back-to-back accepts: tx_rdy=0 in CALC and ISSUE.
- atx_start and atx_start_last are combinational from atx_vld & atx_rdy and the registered last flag.

## Test plan
- Single burst: DATA_W=32, tx_len=3, src=0x1000, dst=0x8000, both INCR, wd_per_burst=15 → one burst: arlen=awlen=3, araddr=0x1000, awaddr=0x8000, atx_start_last=1; tx_rdy back at cycle T+3 when atx_rdy is tied 1.
- Split: tx_len=39, wd_per_burst=15, src=0x1000, dst=0x8000, INCR → three bursts: arlen 15/15/7; araddr 0x1000, 0x1040, 0x1080; atx_start_last only on the third.
- 4 KB split: src=0x0FF0, dst=0x2FF8, tx_len=9, wd_per_burst=15 → bursts of 2, 2, 6 words:
  - araddr 0x0FF0/0x0FF8/0x1000.
  - awaddr 0x2FF8/0x3000/0x3008.
- FIXED clamp: src FIXED, dst INCR, tx_len=39, wd_per_burst=255 → bursts of 16, 16, 8 words; araddr constant at its start value; awaddr steps by 0x40.
- Backpressure and CSR snapshot:
  - Hold atx_rdy=0 for 5 cycles and change atx_wd_per_burst and atx_id during ISSUE → all outputs stable, and the next burst uses the snapshotted CSR values.
  - atx_start asserts exactly once per burst.
- Reset mid-transfer: assert rst in the ISSUE state of the second of three bursts → next cycle atx_vld=0 and busy=0; tx_rdy=1 after release; a new transaction is issued cleanly from its own start address.

Source files
------------

// File: rtl/adma_as_atx_burst_gen.sv
// Boundary-aware AXI burst generator for the ADMA address path.
// Accepts one DMA transaction, snapshots the burst CSRs, and emits a sequence
// of matched AR/AW bursts limited by CSR length, AxLEN range, the FIXED-burst
// beat limit and the AXI address boundary on each side.
module adma_as_atx_burst_gen #(
  parameter int DMA_CHN_NUM   = 4,
  parameter int DMA_LENGTH_W  = 16,
  parameter int SRC_ADDR_W    = 32,
  parameter int DST_ADDR_W    = 32,
  parameter int MST_ID_W      = 5,
  parameter int ATX_LEN_W     = 8,
  parameter int DATA_W        = 32,
  parameter int BOUND_W       = 12,
  parameter int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DMA_CHN_NUM_W-1:0] tx_chn_id,
  input  logic [SRC_ADDR_W-1:0]    tx_src_addr,
  input  logic [DST_ADDR_W-1:0]    tx_dst_addr,
  input  logic [DMA_LENGTH_W-1:0]  tx_len,
  input  logic                     tx_vld,
  output logic                     tx_rdy,
  input  logic [MST_ID_W-1:0]      atx_id,
  input  logic [1:0]               atx_src_burst,
  input  logic [1:0]               atx_dst_burst,
  input  logic [DMA_LENGTH_W-1:0]  atx_wd_per_burst,
  output logic [MST_ID_W-1:0]      arid,
  output logic [SRC_ADDR_W-1:0]    araddr,
  output logic [ATX_LEN_W-1:0]     arlen,
  output logic [1:0]               arburst,
  output logic [MST_ID_W-1:0]      awid,
  output logic [DST_ADDR_W-1:0]    awaddr,
  output logic [ATX_LEN_W-1:0]     awlen,
  output logic [1:0]               awburst,
  output logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
  output logic                     atx_vld,
  input  logic                     atx_rdy,
  output logic                     atx_start,
  output logic                     atx_start_last,
  output logic                     busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int RW    = DMA_LENGTH_W + 1;
  localparam int CW    = RW + BOUND_W + ATX_LEN_W + 1;
  localparam logic [CW-1:0] LEN_MAX = CW'(1) << ATX_LEN_W;
  localparam logic [CW-1:0] FIX_MAX = CW'(16);
  localparam logic [CW-1:0] BOUND   = CW'(1) << BOUND_W;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE} state_t;

  state_t                   state_q, state_d;
  logic [DMA_CHN_NUM_W-1:0] chn_id_q, chn_id_d;
  logic [SRC_ADDR_W-1:0]    src_addr_q, src_addr_d;
  logic [DST_ADDR_W-1:0]    dst_addr_q, dst_addr_d;
  logic [RW-1:0]            rem_q, rem_d;
  logic [RW-1:0]            cap_q, cap_d;
  logic [MST_ID_W-1:0]      id_q, id_d;
  logic                     src_incr_q, src_incr_d;
  logic                     dst_incr_q, dst_incr_d;
  logic [CW-1:0]            n_q, n_d;
  logic                     last_q, last_d;
  logic [ATX_LEN_W-1:0]     len_q, len_d;
  logic [SRC_ADDR_W-1:0]    araddr_q, araddr_d;
  logic [DST_ADDR_W-1:0]    awaddr_q, awaddr_d;

  logic [CW-1:0] n_calc, src_bnd, dst_bnd;

  // Burst word count: minimum of every limit that applies to the current burst.
  always_comb begin
    src_bnd = (BOUND - CW'(src_addr_q[BOUND_W-1:0])) >> BSH;
    dst_bnd = (BOUND - CW'(dst_addr_q[BOUND_W-1:0])) >> BSH;
    n_calc  = CW'(rem_q);
    if (CW'(cap_q) < n_calc) n_calc = CW'(cap_q);
    if (LEN_MAX < n_calc) n_calc = LEN_MAX;
    if (!(src_incr_q && dst_incr_q) && (FIX_MAX < n_calc)) n_calc = FIX_MAX;
    if (src_incr_q && (src_bnd < n_calc)) n_calc = src_bnd;
    if (dst_incr_q && (dst_bnd < n_calc)) n_calc = dst_bnd;
  end

  // Next-state and datapath updates for accept / compute / issue.
  always_comb begin
    state_d    = state_q;
    chn_id_d   = chn_id_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    rem_d      = rem_q;
    cap_d      = cap_q;
    id_d       = id_q;
    src_incr_d = src_incr_q;
    dst_incr_d = dst_incr_q;
    n_d        = n_q;
    last_d     = last_q;
    len_d      = len_q;
    araddr_d   = araddr_q;
    awaddr_d   = awaddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (tx_vld) begin
          chn_id_d   = tx_chn_id;
          src_addr_d = tx_src_addr;
          dst_addr_d = tx_dst_addr;
          rem_d      = RW'(tx_len) + RW'(1);
          cap_d      = RW'(atx_wd_per_burst) + RW'(1);
          id_d       = atx_id;
          // Anything other than INCR, including reserved codes, behaves as FIXED.
          src_incr_d = (atx_src_burst == 2'b01);
          dst_incr_d = (atx_dst_burst == 2'b01);
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        n_d      = n_calc;
        len_d    = ATX_LEN_W'(n_calc - CW'(1));
        last_d   = (CW'(rem_q) == n_calc);
        araddr_d = src_addr_q;
        awaddr_d = dst_addr_q;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        if (atx_rdy) begin
          rem_d = rem_q - RW'(n_q);
          if (src_incr_q) src_addr_d = src_addr_q + (SRC_ADDR_W'(n_q) << BSH);
          if (dst_incr_q) dst_addr_d = dst_addr_q + (DST_ADDR_W'(n_q) << BSH);
          state_d = last_q ? S_IDLE : S_CALC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      chn_id_q   <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      rem_q      <= '0;
      cap_q      <= '0;
      id_q       <= '0;
      src_incr_q <= 1'b0;
      dst_incr_q <= 1'b0;
      n_q        <= '0;
      last_q     <= 1'b0;
      len_q      <= '0;
      araddr_q   <= '0;
      awaddr_q   <= '0;
    end else begin
      state_q    <= state_d;
      chn_id_q   <= chn_id_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      rem_q      <= rem_d;
      cap_q      <= cap_d;
      id_q       <= id_d;
      src_incr_q <= src_incr_d;
      dst_incr_q <= dst_incr_d;
      n_q        <= n_d;
      last_q     <= last_d;
      len_q      <= len_d;
      araddr_q   <= araddr_d;
      awaddr_q   <= awaddr_d;
    end
  end

  // Output decode.
  always_comb begin
    tx_rdy         = (state_q == S_IDLE) && !rst;
    busy           = (state_q != S_IDLE);
    atx_vld        = (state_q == S_ISSUE);
    atx_start      = atx_vld && atx_rdy;
    atx_start_last = atx_start && last_q;
    atx_chn_id     = chn_id_q;
    arid           = id_q;
    awid           = id_q;
    araddr         = araddr_q;
    awaddr         = awaddr_q;
    arlen          = len_q;
    awlen          = len_q;
    arburst        = {1'b0, src_incr_q};
    awburst        = {1'b0, dst_incr_q};
  end

endmodule
